csa_accumulator_ctrl: RTL and testbench

//  Sequencer for a multi-beat signed accumulation job built on one compressor_4_2_n_bit instance.
//  - Accepts two signed operands per beat over a valid/ready handshake.
//  - Keeps the running total in carry-save form: sum_q/carry_q feed back into two compressor inputs.
//  - After LEN beats, resolves the total with one carry-propagate add and presents it on a valid/ready result port.
//  - Sits between the operand/partial-product source and the downstream result consumer.

---
 rtl/csa_accumulator_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_csa_accumulator_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_accumulator_ctrl.sv
// Carry-save multi-beat signed accumulator with valid/ready operand and result ports.
// The running total stays in sum/carry form until a single carry-propagate add at the end.

// 4:2 compressor: two full-adder rows per bit, with a horizontal carry between the rows.
// sum_o + carry_o equals a_i + b_i + c_i + d_i modulo 2^OUT_SIZE (OUT_SIZE = IN_SIZE + 1).
module compressor_4_2_n_bit #(
    parameter int IN_SIZE  = 20,
    parameter int OUT_SIZE = 21
) (
    input  logic [IN_SIZE-1:0]  a_i,
    input  logic [IN_SIZE-1:0]  b_i,
    input  logic [IN_SIZE-1:0]  c_i,
    input  logic [IN_SIZE-1:0]  d_i,
    output logic [OUT_SIZE-1:0] sum_o,
    output logic [OUT_SIZE-1:0] carry_o
);

    logic [IN_SIZE-1:0] s1;
    logic [IN_SIZE-1:0] co1;
    logic [IN_SIZE-1:0] cin;
    logic [IN_SIZE-1:0] s2;
    logic [IN_SIZE-1:0] co2;

    // The first-row carry of bit i becomes the horizontal carry-in of bit i+1.
    assign cin = {co1[IN_SIZE-2:0], 1'b0};

    // Two full-adder rows computed bitwise.
    always_comb begin
        s1  = a_i ^ b_i ^ c_i;
        co1 = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
        s2  = s1 ^ d_i ^ cin;
        co2 = (s1 & d_i) | (s1 & cin) | (d_i & cin);
    end

    // The top first-row carry lands in the extra sum bit; second-row carries shift up one.
    assign sum_o   = {co1[IN_SIZE-1], s2};
    assign carry_o = {co2, 1'b0};

endmodule

module csa_accumulator_ctrl #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 20,
    parameter int LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [IN_W-1:0]  op_a_i,
    input  logic [IN_W-1:0]  op_b_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [ACC_W-1:0] res_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [ACC_W-1:0] carry_q, carry_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [ACC_W-1:0] res_q, res_d;
    logic             op_ready_q, op_ready_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q, busy_d;

    logic [ACC_W-1:0] ext_a;
    logic [ACC_W-1:0] ext_b;
    logic [ACC_W:0]   cmp_sum;
    logic [ACC_W:0]   cmp_carry;
    logic             op_hs;
    logic             unused_msb;

    assign ext_a = {{(ACC_W-IN_W){op_a_i[IN_W-1]}}, op_a_i};
    assign ext_b = {{(ACC_W-IN_W){op_b_i[IN_W-1]}}, op_b_i};

    compressor_4_2_n_bit #(
        .IN_SIZE  (ACC_W),
        .OUT_SIZE (ACC_W + 1)
    ) u_cmp (
        .a_i     (ext_a),
        .b_i     (ext_b),
        .c_i     (sum_q),
        .d_i     (carry_q),
        .sum_o   (cmp_sum),
        .carry_o (cmp_carry)
    );

    // Arithmetic is modulo 2^ACC_W, so the compressor's top bits are dropped.
    assign unused_msb = cmp_sum[ACC_W] ^ cmp_carry[ACC_W];

    // Ready is a registered copy of the state, so the handshake never loops through op_valid_i.
    assign op_hs = op_valid_i & op_ready_q;

    // Next-state, datapath updates and the registered outputs for the following state.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        len_d   = len_i;
                        sum_d   = '0;
                        carry_d = '0;
                        cnt_d   = '0;
                        state_d = ACCUM;
                    end else begin
                        res_d   = '0;
                        state_d = DONE;
                    end
                end
            end
            ACCUM: begin
                if (op_hs) begin
                    sum_d   = cmp_sum[ACC_W-1:0];
                    carry_d = cmp_carry[ACC_W-1:0];
                    cnt_d   = cnt_q + ONE;
                    if (cnt_q == len_q - ONE) begin
                        state_d = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                res_d   = sum_q + carry_q;
                state_d = DONE;
            end
            DONE: begin
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        op_ready_d  = (state_d == ACCUM);
        res_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State, accumulator and output registers; reset discards any job in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            carry_q     <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            res_q       <= '0;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            res_q       <= res_d;
            op_ready_q  <= op_ready_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign op_ready_o  = op_ready_q;
    assign res_valid_o = res_valid_q;
    assign busy_o      = busy_q;
    assign res_o       = res_valid_q ? res_q : '0;

endmodule

// File: tb/tb_csa_accumulator_ctrl.sv
// Bench for csa_accumulator_ctrl: directed job table, hand-written corner sequences,
// and random jobs checked against a plain-integer sum model (ACC_W=20 and ACC_W=16 builds).
module tb_csa_accumulator_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [15:0] len_i;
    logic        op_valid_i;
    logic [7:0]  op_a_i;
    logic [7:0]  op_b_i;
    logic        res_ready_i;

    logic        op_ready_o,  op_ready16;
    logic        res_valid_o, res_valid16;
    logic        busy_o,      busy16;
    logic [19:0] res_o;
    logic [15:0] res16;

    int n_checks = 0;
    int n_pass   = 0;

    int qa[$];
    int qb[$];

    typedef struct {
        int          len;
        int          a;
        int          b;
        logic [19:0] e20;
        logic [15:0] e16;
    } vec_t;

    vec_t vecs[6];

    csa_accumulator_ctrl #(.IN_W(8), .ACC_W(20), .LEN_W(16)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start_i),
        .len_i       (len_i),
        .op_valid_i  (op_valid_i),
        .op_ready_o  (op_ready_o),
        .op_a_i      (op_a_i),
        .op_b_i      (op_b_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_o       (res_o),
        .busy_o      (busy_o)
    );

    csa_accumulator_ctrl #(.IN_W(8), .ACC_W(16), .LEN_W(16)) dut16 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start_i),
        .len_i       (len_i),
        .op_valid_i  (op_valid_i),
        .op_ready_o  (op_ready16),
        .op_a_i      (op_a_i),
        .op_b_i      (op_b_i),
        .res_valid_o (res_valid16),
        .res_ready_i (res_ready_i),
        .res_o       (res16),
        .busy_o      (busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, {31'd0, op_ready_o}, 0);
        chk({tag, "_valid"}, {31'd0, res_valid_o}, 0);
        chk({tag, "_busy"}, {31'd0, busy_o}, 0);
        chk({tag, "_res"}, {12'd0, res_o}, 0);
        chk({tag, "_res16"}, {16'd0, res16}, 0);
        chk({tag, "_busy16"}, {31'd0, busy16}, 0);
    endtask

    task automatic fill_const(input int len, input int a, input int b);
        qa.delete();
        qb.delete();
        for (int k = 0; k < len; k++) begin
            qa.push_back(a);
            qb.push_back(b);
        end
    endtask

    // Reference: the result is the plain integer sum of all operands, reduced mod 2^W.
    task automatic model(input int len, output logic [19:0] e20, output logic [15:0] e16);
        int total;
        logic [31:0] t;
        total = 0;
        for (int k = 0; k < len; k++) total += qa[k] + qb[k];
        t   = total;
        e20 = t[19:0];
        e16 = t[15:0];
    endtask

    // Feed one beat from the queues with an optional leading bubble; returns 0 on timeout.
    task automatic send_beat(input int k, input int max_gap, output bit ok);
        int t;
        int ga;
        int gb;
        ok = 1'b1;
        op_valid_i = 1'b0;
        repeat ($urandom_range(max_gap, 0)) tick();
        ga = qa[k];
        gb = qb[k];
        op_a_i = ga[7:0];
        op_b_i = gb[7:0];
        op_valid_i = 1'b1;
        t = 0;
        while (!op_ready_o && t < 20) begin
            tick();
            t++;
        end
        if (!op_ready_o) begin
            chk("beat_timeout", 0, 1);
            ok = 1'b0;
        end else begin
            tick();
        end
        op_valid_i = 1'b0;
    endtask

    task automatic run_job(input string tag, input int len, input int max_gap,
                           input int hold, input bit pulse_start,
                           input logic [19:0] e20, input logic [15:0] e16);
        bit ok;
        start_i = 1'b1;
        len_i   = 16'(len);
        tick();
        start_i = 1'b0;
        len_i   = '0;
        chk({tag, "_busy_start"}, {31'd0, busy_o}, 1);
        if (len == 0) begin
            chk({tag, "_len0_valid"}, {31'd0, res_valid_o}, 1);
        end else begin
            for (int k = 0; k < len; k++) begin
                send_beat(k, max_gap, ok);
                if (!ok) return;
            end
            chk({tag, "_lat1_valid"}, {31'd0, res_valid_o}, 0);
            chk({tag, "_lat1_busy"}, {31'd0, busy_o}, 1);
            tick();
            chk({tag, "_lat2_valid"}, {31'd0, res_valid_o}, 1);
        end
        chk({tag, "_done_ready"}, {31'd0, op_ready_o}, 0);
        chk({tag, "_res"}, {12'd0, res_o}, {12'd0, e20});
        chk({tag, "_res16"}, {16'd0, res16}, {16'd0, e16});
        for (int h = 0; h < hold; h++) begin
            if (pulse_start && h == 1) begin
                start_i = 1'b1;
                len_i   = 16'd5;
            end
            tick();
            start_i = 1'b0;
            len_i   = '0;
            chk({tag, "_hold_valid"}, {31'd0, res_valid_o}, 1);
            chk({tag, "_hold_res"}, {12'd0, res_o}, {12'd0, e20});
            chk({tag, "_hold_ready"}, {31'd0, op_ready_o}, 0);
        end
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        chk({tag, "_after_valid"}, {31'd0, res_valid_o}, 0);
        chk({tag, "_after_busy"}, {31'd0, busy_o}, 0);
        chk({tag, "_after_res"}, {12'd0, res_o}, 0);
        if (pulse_start) begin
            tick();
            chk({tag, "_ignored_start"}, {31'd0, busy_o}, 0);
        end
    endtask

    initial begin
        logic [19:0] e20;
        logic [15:0] e16;
        bit ok;

        vecs[0] = '{len: 4,   a: -128, b: -128, e20: 20'hFFC00, e16: 16'hFC00};
        vecs[1] = '{len: 1,   a: 7,    b: -3,   e20: 20'h00004, e16: 16'h0004};
        vecs[2] = '{len: 2,   a: 100,  b: -50,  e20: 20'h00064, e16: 16'h0064};
        vecs[3] = '{len: 5,   a: -1,   b: -1,   e20: 20'hFFFF6, e16: 16'hFFF6};
        vecs[4] = '{len: 0,   a: 0,    b: 0,    e20: 20'h00000, e16: 16'h0000};
        vecs[5] = '{len: 300, a: 127,  b: 127,  e20: 20'h129A8, e16: 16'h29A8};

        rst_n = 1'b0;
        start_i = 1'b0;
        len_i = '0;
        op_valid_i = 1'b0;
        op_a_i = '0;
        op_b_i = '0;
        res_ready_i = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        qa = '{1, 3, 5};
        qb = '{2, 4, 6};
        run_job("seq3", 3, 0, 0, 1'b0, 20'h00015, 16'h0015);

        for (int i = 0; i < 6; i++) begin
            fill_const(vecs[i].len, vecs[i].a, vecs[i].b);
            run_job($sformatf("vec%0d", i), vecs[i].len, 0, 1, 1'b0, vecs[i].e20, vecs[i].e16);
        end

        qa = '{-20, 50, 33};
        qb = '{9, -7, 1};
        model(3, e20, e16);
        run_job("done_hold", 3, 3, 5, 1'b1, e20, e16);

        fill_const(4, 10, 10);
        start_i = 1'b1;
        len_i = 16'd4;
        tick();
        start_i = 1'b0;
        len_i = '0;
        send_beat(0, 0, ok);
        send_beat(1, 0, ok);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        tick();
        rst_n = 1'b1;
        tick();
        chk_all_zero("post_reset");
        fill_const(1, 7, -3);
        run_job("after_rst", 1, 0, 0, 1'b0, 20'h00004, 16'h0004);

        for (int j = 0; j < 10; j++) begin
            int len;
            len = $urandom_range(12, 1);
            qa.delete();
            qb.delete();
            for (int k = 0; k < len; k++) begin
                qa.push_back(int'($urandom_range(255, 0)) - 128);
                qb.push_back(int'($urandom_range(255, 0)) - 128);
            end
            model(len, e20, e16);
            run_job($sformatf("rnd%0d", j), len, 2, $urandom_range(3, 0), 1'b0, e20, e16);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
